// File: rtl/phy_reset_ordset_tx_if.sv
// Protocol-layer <-> PHY reset-signalling bus: request/abort in, ack/status/line out.
// STATE_DBG mirrors the transmitter FSM state for observation.
interface phy_reset_ordset_tx_if;
    // Handshake: the request is taken only in IDLE on a cycle with TX_REQ=1,
    // a legal TX_TYPE and STOP_ATTEMPT=0; PHY_ACK/ABORTED are one-cycle completions.
    logic       TX_REQ;
    logic [2:0] TX_TYPE;
    logic       STOP_ATTEMPT;
    logic       PHY_ACK;
    logic [2:0] ACK_TYPE;
    logic       ABORTED;
    logic       BUSY;
    logic       TX_EN;
    logic       BMC_OUT;
    logic [2:0] STATE_DBG;

    modport master (
        output TX_REQ, TX_TYPE, STOP_ATTEMPT,
        input  PHY_ACK, ACK_TYPE, ABORTED, BUSY, TX_EN, BMC_OUT, STATE_DBG
    );

    modport slave (
        input  TX_REQ, TX_TYPE, STOP_ATTEMPT,
        output PHY_ACK, ACK_TYPE, ABORTED, BUSY, TX_EN, BMC_OUT, STATE_DBG
    );
endinterface

// File: rtl/phy_reset_ordset_tx.sv
// Hard Reset / Cable Reset ordered-set transmitter: preamble + 4 K-codes, BMC encoded,
// followed by a one-cycle PHY_ACK, with abort on STOP_ATTEMPT.
module phy_reset_ordset_tx #(
    parameter int HALF_BIT_CYCLES = 5,
    parameter int PREAMBLE_BITS   = 64
) (
    input  logic                 CLK,
    input  logic                 reset,
    phy_reset_ordset_tx_if.slave bus
);
    localparam int          MAX_BITS = (PREAMBLE_BITS > 20) ? PREAMBLE_BITS : 20;
    localparam int          IDX_W    = $clog2(MAX_BITS);
    localparam int          HC_W     = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam logic [2:0]  TYPE_HARD  = 3'b101;
    localparam logic [2:0]  TYPE_CABLE = 3'b110;

    // K-codes MSB..LSB; each is shifted out LSB first.
    localparam logic [4:0]  K_SYNC1 = 5'b11000;
    localparam logic [4:0]  K_RST1  = 5'b00111;
    localparam logic [4:0]  K_RST2  = 5'b11001;
    localparam logic [4:0]  K_SYNC3 = 5'b00110;
    // Ordered-set words: bit i is the i-th bit on the line.
    localparam logic [19:0] WORD_HARD  = {K_RST2,  K_RST1, K_RST1,  K_RST1};
    localparam logic [19:0] WORD_CABLE = {K_SYNC3, K_RST1, K_SYNC1, K_RST1};

    localparam logic [HC_W-1:0]  HALF_LAST = HC_W'(HALF_BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_BITS - 1);
    localparam logic [IDX_W-1:0] OS_LAST   = IDX_W'(19);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_ORDSET   = 3'd2,
        S_TAIL     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t           state_q;
    logic [HC_W-1:0]  half_cnt_q;
    logic             phase_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic [2:0]       type_q;
    logic             phy_ack_q;
    logic             aborted_q;
    logic             busy_q;
    logic             tx_en_q;
    logic             bmc_q;

    logic        accept_d;
    logic [19:0] word_d;
    logic [4:0]  os_idx_d;
    logic        cur_bit_d;
    logic        last_bit_d;
    logic        half_end_d;

    always_comb begin
        accept_d   = bus.TX_REQ && !bus.STOP_ATTEMPT &&
                     ((bus.TX_TYPE == TYPE_HARD) || (bus.TX_TYPE == TYPE_CABLE));
        word_d     = (type_q == TYPE_HARD) ? WORD_HARD : WORD_CABLE;
        os_idx_d   = bit_idx_q[4:0];
        // Preamble alternates starting with 0, so the bit is the index LSB.
        cur_bit_d  = (state_q == S_PREAMBLE) ? bit_idx_q[0] : word_d[os_idx_d];
        last_bit_d = (state_q == S_PREAMBLE) ? (bit_idx_q == PRE_LAST) : (bit_idx_q == OS_LAST);
        half_end_d = (half_cnt_q == HALF_LAST);
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            half_cnt_q <= '0;
            phase_q    <= 1'b0;
            bit_idx_q  <= '0;
            type_q     <= 3'b000;
            phy_ack_q  <= 1'b0;
            aborted_q  <= 1'b0;
            busy_q     <= 1'b0;
            tx_en_q    <= 1'b0;
            bmc_q      <= 1'b0;
        end else begin
            phy_ack_q <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        state_q    <= S_PREAMBLE;
                        type_q     <= bus.TX_TYPE;
                        busy_q     <= 1'b1;
                        tx_en_q    <= 1'b1;
                        bmc_q      <= 1'b1;  // first bit starts with a toggle from idle 0
                        half_cnt_q <= '0;
                        phase_q    <= 1'b0;
                        bit_idx_q  <= '0;
                    end
                end
                S_PREAMBLE, S_ORDSET, S_TAIL: begin
                    if (bus.STOP_ATTEMPT) begin
                        state_q    <= S_IDLE;
                        aborted_q  <= 1'b1;
                        busy_q     <= 1'b0;
                        tx_en_q    <= 1'b0;
                        bmc_q      <= 1'b0;
                        half_cnt_q <= '0;
                        phase_q    <= 1'b0;
                        bit_idx_q  <= '0;
                    end else if (!half_end_d) begin
                        half_cnt_q <= half_cnt_q + 1'b1;
                    end else if (!phase_q) begin
                        half_cnt_q <= '0;
                        phase_q    <= 1'b1;
                        if (state_q != S_TAIL && cur_bit_d) begin
                            bmc_q <= ~bmc_q;
                        end
                    end else begin
                        half_cnt_q <= '0;
                        phase_q    <= 1'b0;
                        if (state_q == S_TAIL) begin
                            state_q   <= S_DONE;
                            phy_ack_q <= 1'b1;
                            tx_en_q   <= 1'b0;
                            bmc_q     <= 1'b0;
                        end else if (!last_bit_d) begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            bmc_q     <= ~bmc_q;
                        end else begin
                            bit_idx_q <= '0;
                            if (state_q == S_PREAMBLE) begin
                                state_q <= S_ORDSET;
                                bmc_q   <= ~bmc_q;
                            end else begin
                                // Line parks low while still driven for one bit time.
                                state_q <= S_TAIL;
                                bmc_q   <= 1'b0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    tx_en_q <= 1'b0;
                    bmc_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PHY_ACK   = phy_ack_q;
    assign bus.ACK_TYPE  = type_q;
    assign bus.ABORTED   = aborted_q;
    assign bus.BUSY      = busy_q;
    assign bus.TX_EN     = tx_en_q;
    assign bus.BMC_OUT   = bmc_q;
    assign bus.STATE_DBG = state_q;
endmodule

// File: tb/tb_phy_reset_ordset_tx.sv
// Directed bench for phy_reset_ordset_tx: records per-cycle outputs after each request,
// decodes the BMC stream and compares against hand-written expected bit patterns.
module tb_phy_reset_ordset_tx;
    logic CLK;
    logic reset;
    phy_reset_ordset_tx_if bus();

    phy_reset_ordset_tx #(.HALF_BIT_CYCLES(5), .PREAMBLE_BITS(64)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests_run = 0;
    int tests_failed = 0;

    logic       cap_bmc  [0:899];
    logic       cap_en   [0:899];
    logic       cap_ack  [0:899];
    logic       cap_abt  [0:899];
    logic       cap_busy [0:899];
    logic [2:0] cap_at   [0:899];

    logic [83:0] dec_vec;
    int          bmc_err;

    // Expected ordered-set bits, leftmost character first on the line.
    localparam logic [19:0] EXP_HARD_OS  = 20'b11100_11100_11100_10011;
    localparam logic [19:0] EXP_CABLE_OS = 20'b11100_00011_11100_01100;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Records cycles 1..n after the request cycle; drives optional mid-run events.
    task automatic capture(input int n, input int req_at, input int stop_at, input int rst_at);
        for (int i = 1; i <= n; i++) begin
            tick();
            cap_bmc[i]  = bus.BMC_OUT;
            cap_en[i]   = bus.TX_EN;
            cap_ack[i]  = bus.PHY_ACK;
            cap_abt[i]  = bus.ABORTED;
            cap_busy[i] = bus.BUSY;
            cap_at[i]   = bus.ACK_TYPE;
            bus.TX_REQ       = (i == req_at);
            bus.STOP_ATTEMPT = (i == stop_at);
            reset            = !(i == rst_at);
        end
        bus.TX_REQ = 1'b0;
        bus.STOP_ATTEMPT = 1'b0;
        reset = 1'b1;
    endtask

    task automatic decode();
        logic prev;
        int   s;
        bmc_err = 0;
        dec_vec = '0;
        for (int k = 0; k < 84; k++) begin
            s = 1 + 10 * k;
            prev = (k == 0) ? 1'b0 : cap_bmc[s - 1];
            if (cap_bmc[s] == prev) bmc_err++;
            for (int j = 1; j < 5; j++) begin
                if (cap_bmc[s + j] != cap_bmc[s]) bmc_err++;
                if (cap_bmc[s + 5 + j] != cap_bmc[s + 5]) bmc_err++;
            end
            dec_vec[k] = (cap_bmc[s + 5] != cap_bmc[s]);
        end
    endtask

    function automatic logic [83:0] exp_stream(input logic [19:0] os);
        logic [83:0] v;
        for (int i = 0; i < 64; i++) v[i] = (i % 2 == 1);
        for (int i = 0; i < 20; i++) v[64 + i] = os[19 - i];
        return v;
    endfunction

    task automatic start_req(input logic [2:0] t);
        bus.TX_TYPE = t;
        bus.TX_REQ  = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.TX_REQ = 1'b0;
        bus.TX_TYPE = 3'b000;
        bus.STOP_ATTEMPT = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({bus.PHY_ACK, bus.ACK_TYPE, bus.ABORTED, bus.BUSY, bus.TX_EN, bus.BMC_OUT} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {bus.PHY_ACK, bus.ACK_TYPE, bus.ABORTED, bus.BUSY, bus.TX_EN, bus.BMC_OUT});
        end
        tests_run++;
        if (bus.STATE_DBG !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected 0", bus.STATE_DBG);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic check_full_run(input string name, input logic [2:0] t, input logic [19:0] os);
        int acks;
        int abts;
        int tail_bad;
        acks = 0; abts = 0; tail_bad = 0;
        for (int i = 1; i <= 860; i++) begin
            acks += int'(cap_ack[i]);
            abts += int'(cap_abt[i]);
        end
        for (int i = 841; i <= 850; i++) if (cap_bmc[i] !== 1'b0 || cap_en[i] !== 1'b1) tail_bad++;
        decode();
        tests_run++;
        if ({cap_busy[1], cap_en[1]} !== 2'b11) begin
            tests_failed++;
            $display("FAIL %s_start: busy/txen got %b expected 11", name, {cap_busy[1], cap_en[1]});
        end
        tests_run++;
        if (bmc_err !== 0) begin
            tests_failed++;
            $display("FAIL %s_bmc_shape: got %0d violations expected 0", name, bmc_err);
        end
        tests_run++;
        if (dec_vec !== exp_stream(os)) begin
            tests_failed++;
            $display("FAIL %s_bits: got %h expected %h", name, dec_vec, exp_stream(os));
        end
        tests_run++;
        if (tail_bad !== 0) begin
            tests_failed++;
            $display("FAIL %s_tail: got %0d bad cycles expected 0", name, tail_bad);
        end
        tests_run++;
        if ({cap_ack[851], cap_at[851], cap_en[851], cap_bmc[851], cap_busy[852]} !== {1'b1, t, 3'b000}) begin
            tests_failed++;
            $display("FAIL %s_done: got %b expected %b", name,
                     {cap_ack[851], cap_at[851], cap_en[851], cap_bmc[851], cap_busy[852]}, {1'b1, t, 3'b000});
        end
        tests_run++;
        if (acks !== 1 || abts !== 0) begin
            tests_failed++;
            $display("FAIL %s_pulses: got ack=%0d abt=%0d expected ack=1 abt=0", name, acks, abts);
        end
        tests_run++;
        if (cap_at[858] !== t) begin
            tests_failed++;
            $display("FAIL %s_ack_type_hold: got %b expected %b", name, cap_at[858], t);
        end
    endtask

    task automatic test_hard_reset();
        start_req(3'b101);
        capture(860, -1, -1, -1);
        check_full_run("hard", 3'b101, EXP_HARD_OS);
    endtask

    task automatic test_cable_reset();
        start_req(3'b110);
        capture(860, -1, -1, -1);
        check_full_run("cable", 3'b110, EXP_CABLE_OS);
    endtask

    task automatic test_invalid_type();
        int busy_seen;
        busy_seen = 0;
        start_req(3'b011);
        capture(20, -1, -1, -1);
        for (int i = 1; i <= 20; i++) busy_seen += int'(cap_busy[i] | cap_ack[i] | cap_en[i]);
        tests_run++;
        if (busy_seen !== 0) begin
            tests_failed++;
            $display("FAIL invalid_type: got %0d active cycles expected 0", busy_seen);
        end
        // A legal request while STOP_ATTEMPT is held must also be refused.
        bus.STOP_ATTEMPT = 1'b1;
        start_req(3'b101);
        tick();
        bus.TX_REQ = 1'b0;
        tick();
        bus.STOP_ATTEMPT = 1'b0;
        tests_run++;
        if (bus.BUSY !== 1'b0 || bus.TX_EN !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_blocks_accept: busy/txen got %b expected 00", {bus.BUSY, bus.TX_EN});
        end
    endtask

    task automatic test_busy_ignore();
        start_req(3'b101);
        bus.TX_TYPE = 3'b101;
        capture(860, 100, -1, -1);
        check_full_run("busy_ignore", 3'b101, EXP_HARD_OS);
    endtask

    task automatic test_abort();
        int acks;
        int abts;
        acks = 0; abts = 0;
        start_req(3'b110);
        capture(860, -1, 400, -1);
        for (int i = 1; i <= 860; i++) begin
            acks += int'(cap_ack[i]);
            abts += int'(cap_abt[i]);
        end
        tests_run++;
        if ({cap_abt[401], cap_en[401], cap_bmc[401], cap_busy[401], cap_ack[401]} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL abort_cycle: got %b expected 10000",
                     {cap_abt[401], cap_en[401], cap_bmc[401], cap_busy[401], cap_ack[401]});
        end
        tests_run++;
        if (acks !== 0 || abts !== 1 || cap_abt[402] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_pulses: got ack=%0d abt=%0d expected ack=0 abt=1", acks, abts);
        end
        start_req(3'b101);
        capture(860, -1, -1, -1);
        check_full_run("after_abort", 3'b101, EXP_HARD_OS);
    endtask

    task automatic test_reset_midop();
        int acks;
        int abts;
        acks = 0; abts = 0;
        start_req(3'b101);
        capture(860, -1, -1, 300);
        for (int i = 1; i <= 860; i++) begin
            acks += int'(cap_ack[i]);
            abts += int'(cap_abt[i]);
        end
        tests_run++;
        if ({cap_ack[301], cap_at[301], cap_abt[301], cap_busy[301], cap_en[301], cap_bmc[301]} !== 8'h00) begin
            tests_failed++;
            $display("FAIL midop_reset_outputs: got %b expected 00000000",
                     {cap_ack[301], cap_at[301], cap_abt[301], cap_busy[301], cap_en[301], cap_bmc[301]});
        end
        tests_run++;
        if (acks !== 0 || abts !== 0) begin
            tests_failed++;
            $display("FAIL midop_reset_pulses: got ack=%0d abt=%0d expected 0/0", acks, abts);
        end
        start_req(3'b110);
        capture(860, -1, -1, -1);
        check_full_run("after_reset", 3'b110, EXP_CABLE_OS);
    endtask

    initial begin
        test_reset();
        test_hard_reset();
        test_cable_reset();
        test_invalid_type();
        test_busy_ignore();
        test_abort();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
